usb_ctrl_readback_tx: RTL and testbench

USB_CTRL_READBACK_TX -- requirements
Module: usb_ctrl_readback_tx

---
 rtl/usb_ctrl_readback_tx_pkg.sv | 36 +++
 rtl/usb_rb_csum.sv | 29 ++
 rtl/usb_ctrl_readback_tx.sv | 134 +++++++++++++
 tb/tb_usb_ctrl_readback_tx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_ctrl_readback_tx_pkg.sv
// Shared USB read-back constants: register addresses, sync bytes,
// per-address payload lengths and the response FSM state encoding.
package usb_ctrl_readback_tx_pkg;

  localparam logic [7:0] SYNC1_BYTE = 8'h5E;
  localparam logic [7:0] SYNC2_BYTE = 8'h4D;
  localparam logic [7:0] LEN_H_BYTE = 8'h00;

  localparam logic [7:0] ADDR_SDI = 8'h08;
  localparam logic [7:0] ADDR_CSI = 8'h0A;

  localparam logic [1:0] LEN_SDI  = 2'd2;
  localparam logic [1:0] LEN_CSI  = 2'd3;
  localparam logic [1:0] LEN_NONE = 2'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC1,
    ST_SYNC2,
    ST_ADDR,
    ST_LEN_H,
    ST_LEN_L,
    ST_DATA,
    ST_CSUM
  } rb_state_e;

  // Number of payload bytes returned for a register address.
  function automatic logic [1:0] addr_len(input logic [7:0] addr);
    case (addr)
      ADDR_SDI: addr_len = LEN_SDI;
      ADDR_CSI: addr_len = LEN_CSI;
      default:  addr_len = LEN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/usb_rb_csum.sv
// XOR accumulator for the read-back frame checksum. Clear wins over enable
// so a new frame always starts from zero.
module usb_rb_csum (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] byte_i,
  output logic [7:0] csum_o
);

  logic [7:0] csum_q;

  // Accumulate every checksummed byte as it is handed off downstream.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      csum_q <= 8'h00;
    end else if (clr_i) begin
      csum_q <= 8'h00;
    end else if (en_i) begin
      // NOTE: sequential state uses non-blocking assignment so every
      // register samples the pre-edge values, independent of block order.
      csum_q <= csum_q ^ byte_i;
    end
  end

  assign csum_o = csum_q;

endmodule

// File: rtl/usb_ctrl_readback_tx.sv
// Control-register read-back transmitter: on a request, snapshots the
// addressed register and streams 5E 4D ADDR 00 LEN DATA.. CSUM to the USB
// FIFO using a valid/ready handshake.
module usb_ctrl_readback_tx
  import usb_ctrl_readback_tx_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        rd_req,
  input  logic [7:0]  rd_addr,
  input  logic [15:0] sdi_cr_q,
  input  logic [23:0] csi_cr_q,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        rd_busy,
  output logic        rd_err
);

  rb_state_e   state_q, state_d;
  logic [7:0]  addr_q;
  logic [1:0]  len_q;
  logic [23:0] data_q;
  logic [1:0]  idx_q;

  logic        accept;
  logic        hs;
  logic        last_data;
  logic [1:0]  req_len;
  logic [23:0] snap_data;
  logic [7:0]  data_byte;
  logic [7:0]  csum;
  logic        csum_en;

  // Requests are only taken from IDLE; anything arriving mid-frame is lost.
  assign accept    = n_rst && (state_q == ST_IDLE) && rd_req;
  assign hs        = tx_valid && tx_ready;
  assign req_len   = addr_len(rd_addr);
  assign last_data = (idx_q == len_q - 2'd1);

  // Snapshot mux: payload is left-aligned so byte 0 is always [23:16].
  always_comb begin
    case (rd_addr)
      ADDR_SDI: snap_data = {sdi_cr_q, 8'h00};
      ADDR_CSI: snap_data = csi_cr_q;
      default:  snap_data = 24'h000000;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one step per handshake.
  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no
    // latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SYNC1;
      ST_SYNC1: if (hs) state_d = ST_SYNC2;
      ST_SYNC2: if (hs) state_d = ST_ADDR;
      ST_ADDR:  if (hs) state_d = ST_LEN_H;
      ST_LEN_H: if (hs) state_d = ST_LEN_L;
      ST_LEN_L: if (hs) state_d = (len_q != LEN_NONE) ? ST_DATA : ST_CSUM;
      ST_DATA:  if (hs && last_data) state_d = ST_CSUM;
      ST_CSUM:  if (hs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Frame snapshot and payload byte index.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr_q <= 8'h00;
      len_q  <= 2'd0;
      data_q <= 24'h000000;
      idx_q  <= 2'd0;
    end else if (accept) begin
      addr_q <= rd_addr;
      len_q  <= req_len;
      data_q <= snap_data;
      idx_q  <= 2'd0;
    end else if (hs && (state_q == ST_DATA)) begin
      idx_q  <= idx_q + 2'd1;
    end
  end

  always_comb begin
    case (idx_q)
      2'd0:    data_byte = data_q[23:16];
      2'd1:    data_byte = data_q[15:8];
      default: data_byte = data_q[7:0];
    endcase
  end

  // Output decode: everything is a function of registered state, so data
  // and valid are inherently stable while the FIFO stalls.
  always_comb begin
    tx_data = 8'h00;
    case (state_q)
      ST_SYNC1: tx_data = SYNC1_BYTE;
      ST_SYNC2: tx_data = SYNC2_BYTE;
      ST_ADDR:  tx_data = addr_q;
      ST_LEN_H: tx_data = LEN_H_BYTE;
      ST_LEN_L: tx_data = {6'd0, len_q};
      ST_DATA:  tx_data = data_byte;
      ST_CSUM:  tx_data = csum;
      default:  tx_data = 8'h00;
    endcase
    tx_valid = (state_q != ST_IDLE);
    rd_busy  = (state_q != ST_IDLE);
    rd_err   = accept && (req_len == LEN_NONE);
  end

  // Sync bytes and the checksum byte itself are excluded from the XOR.
  assign csum_en = hs && ((state_q == ST_ADDR) || (state_q == ST_LEN_H) ||
                          (state_q == ST_LEN_L) || (state_q == ST_DATA));

  usb_rb_csum u_csum (
    .clk    (clk),
    .n_rst  (n_rst),
    .clr_i  (accept),
    .en_i   (csum_en),
    .byte_i (tx_data),
    .csum_o (csum)
  );

endmodule

// File: tb/tb_usb_ctrl_readback_tx.sv
// Bench for usb_ctrl_readback_tx: directed vectors from a table, stall and
// disturbance sequences, reset abort, and randomized frames against a
// frame-building reference model.
module tb_usb_ctrl_readback_tx;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    string       name;
    logic [7:0]  addr;
    logic [15:0] sdi;
    logic [23:0] csi;
    int          ready_mode;  // 0: always ready, 1: 1,0,0,1 pattern
    int          exp_busy;    // 0 means do not check
    int          nbytes;
    logic [7:0]  bytes[9];
  } vec_t;

  logic        clk;
  logic        n_rst;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic [15:0] sdi_cr_q;
  logic [23:0] csi_cr_q;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        rd_busy;
  logic        rd_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  usb_ctrl_readback_tx dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .sdi_cr_q (sdi_cr_q),
    .csi_cr_q (csi_cr_q),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rd_busy  (rd_busy),
    .rd_err   (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: the frame is derived from the register map, not from states.
  function automatic bq_t model_frame(input logic [7:0] addr, input logic [15:0] sdi,
                                      input logic [23:0] csi);
    bq_t f;
    int n;
    logic [23:0] val;
    logic [7:0] cs;
    if (addr == 8'h08) begin n = 2; val = {8'h00, sdi}; end
    else if (addr == 8'h0A) begin n = 3; val = csi; end
    else begin n = 0; val = 24'h0; end
    f.push_back(8'h5E);
    f.push_back(8'h4D);
    f.push_back(addr);
    f.push_back(8'h00);
    f.push_back(8'(n));
    cs = addr ^ 8'(n);
    for (int i = n - 1; i >= 0; i--) begin
      f.push_back(8'((val >> (8 * i)) & 24'hFF));
      cs = cs ^ 8'((val >> (8 * i)) & 24'hFF);
    end
    f.push_back(cs);
    return f;
  endfunction

  // Issue one request and collect the frame; ready_mode 2 is random ready.
  task automatic run_frame(input string name, input logic [7:0] addr, input bq_t exp,
                           input int ready_mode, input int exp_busy, input bit disturb);
    bq_t got;
    int busy_cycles = 0;
    int cyc = 0;
    bit prev_stall = 0;
    bit stable_ok = 1;
    logic [7:0] prev_data = 8'h00;
    @(negedge clk);
    rd_addr  = addr;
    rd_req   = 1'b1;
    tx_ready = 1'b0;
    #1;
    check({name, " rd_err"}, {31'd0, rd_err}, {31'd0, exp.size() == 6});
    @(negedge clk);
    rd_req = 1'b0;
    while (cyc < 64) begin
      if (!rd_busy) break;
      busy_cycles++;
      if (!tx_valid) stable_ok = 0;
      if (prev_stall && tx_data !== prev_data) stable_ok = 0;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: tx_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (disturb && cyc == 3) begin
        csi_cr_q = ~csi_cr_q;
        rd_addr  = 8'h11;
        rd_req   = 1'b1;
        #1;
        check({name, " ignored req rd_err"}, {31'd0, rd_err}, 32'd0);
      end else begin
        rd_req = 1'b0;
      end
      if (tx_ready) got.push_back(tx_data);
      prev_stall = !tx_ready;
      prev_data  = tx_data;
      cyc++;
      @(negedge clk);
    end
    rd_req   = 1'b0;
    tx_ready = 1'b0;
    check({name, " finished in budget"}, {31'd0, cyc < 64}, 32'd1);
    check({name, " idle tx_valid"}, {31'd0, tx_valid}, 32'd0);
    check({name, " byte count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s byte%0d", name, i), {24'd0, got[i]}, {24'd0, exp[i]});
    check({name, " valid/data stable"}, {31'd0, stable_ok}, 32'd1);
    if (exp_busy != 0) check({name, " busy cycles"}, busy_cycles, exp_busy);
  endtask

  vec_t vecs[4];

  initial begin
    bq_t exp;
    logic [7:0] ra;
    vecs[0] = '{"sdi", 8'h08, 16'h0920, 24'h0, 0, 8, 8,
                '{8'h5E, 8'h4D, 8'h08, 8'h00, 8'h02, 8'h09, 8'h20, 8'h23, 8'h00}};
    vecs[1] = '{"csi", 8'h0A, 16'h0, 24'h030005, 0, 9, 9,
                '{8'h5E, 8'h4D, 8'h0A, 8'h00, 8'h03, 8'h03, 8'h00, 8'h05, 8'h0F}};
    vecs[2] = '{"unknown", 8'h11, 16'h0, 24'h0, 0, 6, 6,
                '{8'h5E, 8'h4D, 8'h11, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00, 8'h00}};
    vecs[3] = '{"sdi stalled", 8'h08, 16'h0920, 24'h0, 1, 0, 8,
                '{8'h5E, 8'h4D, 8'h08, 8'h00, 8'h02, 8'h09, 8'h20, 8'h23, 8'h00}};

    n_rst = 1'b0; rd_req = 1'b1; rd_addr = 8'h11; tx_ready = 1'b1;
    sdi_cr_q = 16'hFFFF; csi_cr_q = 24'hFFFFFF;
    repeat (3) @(negedge clk);
    check("reset tx_valid", {31'd0, tx_valid}, 32'd0);
    check("reset tx_data", {24'd0, tx_data}, 32'd0);
    check("reset rd_busy", {31'd0, rd_busy}, 32'd0);
    check("reset rd_err", {31'd0, rd_err}, 32'd0);
    rd_req = 1'b0; tx_ready = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;

    // Directed vectors.
    for (int v = 0; v < 4; v++) begin
      exp.delete();
      for (int i = 0; i < vecs[v].nbytes; i++) exp.push_back(vecs[v].bytes[i]);
      sdi_cr_q = vecs[v].sdi;
      csi_cr_q = vecs[v].csi;
      run_frame(vecs[v].name, vecs[v].addr, exp, vecs[v].ready_mode, vecs[v].exp_busy, 1'b0);
    end

    // Register change and a second request during a CSI frame.
    csi_cr_q = 24'h030005;
    exp = '{8'h5E, 8'h4D, 8'h0A, 8'h00, 8'h03, 8'h03, 8'h00, 8'h05, 8'h0F};
    run_frame("csi disturbed", 8'h0A, exp, 0, 9, 1'b1);
    @(negedge clk);
    check("dropped req no frame", {31'd0, rd_busy}, 32'd0);

    // Reset while streaming payload, then a clean frame.
    sdi_cr_q = 16'h0920;
    @(negedge clk);
    rd_addr = 8'h08; rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0; tx_ready = 1'b1;
    repeat (5) @(negedge clk);   // SYNC1..LEN_L handed off; now in DATA
    check("pre-reset in frame", {31'd0, rd_busy}, 32'd1);
    n_rst = 1'b0;
    #1;
    check("abort tx_valid", {31'd0, tx_valid}, 32'd0);
    check("abort rd_busy", {31'd0, rd_busy}, 32'd0);
    check("abort tx_data", {24'd0, tx_data}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1; tx_ready = 1'b0;
    exp = model_frame(8'h08, 16'h0920, 24'h0);
    run_frame("after reset", 8'h08, exp, 0, 8, 1'b0);

    // Randomized frames against the reference model.
    for (int r = 0; r < 20; r++) begin
      case ($urandom_range(0, 2))
        0:       ra = 8'h08;
        1:       ra = 8'h0A;
        default: ra = 8'($urandom_range(0, 255));
      endcase
      sdi_cr_q = 16'($urandom);
      csi_cr_q = 24'($urandom);
      exp = model_frame(ra, sdi_cr_q, csi_cr_q);
      run_frame($sformatf("rand%0d", r), ra, exp, 2, 0, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
